// File: rtl/gate_scheduler_pkg.sv
// Shared definitions for gate_scheduler.
//   OP_*     : 2-bit opcodes for the bitwise logic unit
//   state_t  : scheduler FSM state encoding
package gate_scheduler_pkg;

  localparam logic [1:0] OP_OR  = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  typedef enum logic {
    StIdle = 1'b0,
    StExec = 1'b1
  } state_t;

endpackage

// File: rtl/logic_unit.sv
// Purely combinational W-bit bitwise logic unit.
//   a, b : operands
//   op   : opcode (OP_OR, OP_AND, OP_XOR, OP_NOR)
//   y    : bitwise result, no carries between bits
module logic_unit
  import gate_scheduler_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   op,
  output logic [W-1:0] y
);

  always_comb begin
    y = '0;
    unique case (op)
      OP_OR:   y = a | b;
      OP_AND:  y = a & b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/gate_scheduler.sv
// Round-robin scheduler sharing one logic_unit among NREQ requesters.
// One operation per two cycles: IDLE captures the winner's operands and
// pulses gnt; EXEC registers the logic-unit output and pulses result_valid.
//   clk, rst_n   : clock, asynchronous active-low reset
//   req          : per-requester request level
//   op           : per-requester opcode, [2i+1:2i]
//   a_in, b_in   : per-requester operands, [W*i+W-1:W*i]
//   gnt          : one-hot grant pulse, cycle after capture
//   result       : registered result, held until next completion
//   result_valid : one-cycle pulse qualifying result/result_id
//   result_id    : index of the requester owning result
module gate_scheduler
  import gate_scheduler_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 8,
  localparam int unsigned IDW = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req,
  input  logic [2*NREQ-1:0]   op,
  input  logic [W*NREQ-1:0]   a_in,
  input  logic [W*NREQ-1:0]   b_in,
  output logic [NREQ-1:0]     gnt,
  output logic [W-1:0]        result,
  output logic                result_valid,
  output logic [IDW-1:0]      result_id
);

  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  win_q, win_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [1:0]      op_q, op_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [W-1:0]    result_q, result_d;
  logic            valid_q, valid_d;

  // Round-robin search: first set req bit at or above ptr_q, modulo NREQ.
  logic [IDW-1:0] win;
  logic [IDW-1:0] cand;
  logic           any_req;

  always_comb begin
    win     = '0;
    cand    = '0;
    any_req = 1'b0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      cand = IDW'((32'(ptr_q) + off) % NREQ);
      if (!any_req && req[cand]) begin
        any_req = 1'b1;
        win     = cand;
      end
    end
  end

  // Operand mux for the current winner, plus its one-hot grant vector.
  logic [1:0]      sel_op;
  logic [W-1:0]    sel_a;
  logic [W-1:0]    sel_b;
  logic [NREQ-1:0] win_onehot;

  always_comb begin
    sel_op     = '0;
    sel_a      = '0;
    sel_b      = '0;
    win_onehot = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win == IDW'(i)) begin
        sel_op        = op[2*i +: 2];
        sel_a         = a_in[W*i +: W];
        sel_b         = b_in[W*i +: W];
        win_onehot[i] = 1'b1;
      end
    end
  end

  // The logic unit only ever sees captured operands, so input changes
  // after capture cannot disturb the in-flight result.
  logic [W-1:0] lu_y;

  logic_unit #(
    .W (W)
  ) u_logic_unit (
    .a  (a_q),
    .b  (b_q),
    .op (op_q),
    .y  (lu_y)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    id_d     = id_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    gnt_d    = '0;
    result_d = result_q;
    valid_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d = StExec;
          ptr_d   = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
          win_d   = win;
          op_d    = sel_op;
          a_d     = sel_a;
          b_d     = sel_b;
          gnt_d   = win_onehot;
        end
      end
      StExec: begin
        state_d  = StIdle;
        result_d = lu_y;
        valid_d  = 1'b1;
        id_d     = win_q;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      win_q    <= '0;
      id_q     <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      gnt_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      id_q     <= id_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      gnt_q    <= gnt_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign gnt          = gnt_q;
  assign result       = result_q;
  assign result_valid = valid_q;
  assign result_id    = id_q;

endmodule

// File: tb/tb_gate_scheduler.sv
// Self-checking bench for gate_scheduler (NREQ=4, W=8). Expected results are
// queued when a request is driven and popped by a monitor on result_valid.
module tb_gate_scheduler;

  localparam int NREQ = 4;
  localparam int W    = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [2*NREQ-1:0] op = '0;
  logic [W*NREQ-1:0] a_in = '0;
  logic [W*NREQ-1:0] b_in = '0;
  logic [NREQ-1:0]   gnt;
  logic [W-1:0]      result;
  logic              result_valid;
  logic [1:0]        result_id;

  gate_scheduler #(
    .NREQ (NREQ),
    .W    (W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .op           (op),
    .a_in         (a_in),
    .b_in         (b_in),
    .gnt          (gnt),
    .result       (result),
    .result_valid (result_valid),
    .result_id    (result_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] res;
    logic [1:0] id;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass = 0;

  function automatic logic [7:0] lu_model(input logic [1:0] o, input logic [7:0] a,
                                          input logic [7:0] b);
    case (o)
      2'b00:   return a | b;
      2'b01:   return a & b;
      2'b10:   return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  task automatic set_ops(input int i, input logic [1:0] o, input logic [7:0] a,
                         input logic [7:0] b);
    op[2*i +: 2]   = o;
    a_in[W*i +: W] = a;
    b_in[W*i +: W] = b;
  endtask

  task automatic push_exp(input int i, input logic [7:0] res);
    exp_t e;
    e.res = res;
    e.id  = 2'(i);
    sb.push_back(e);
  endtask

  // Scoreboard monitor: every result_valid must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && result_valid) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_result_valid: result=%h id=%0d, required no result",
                 result, result_id);
      end else begin
        mon_e = sb.pop_front();
        if (result !== mon_e.res || result_id !== mon_e.id)
          $display("FAIL result: got %h id %0d, required %h id %0d",
                   result, result_id, mon_e.res, mon_e.id);
        else
          n_pass++;
      end
    end
  end

  task automatic test_reset;
    rst_n = 1'b0;
    req   = '1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (gnt !== 4'b0000) $display("FAIL reset_gnt: got %b, required 0000", gnt);
    else n_pass++;
    n_checks++;
    if (result !== 8'h00) $display("FAIL reset_result: got %h, required 00", result);
    else n_pass++;
    n_checks++;
    if (result_valid !== 1'b0)
      $display("FAIL reset_valid: got %b, required 0", result_valid);
    else n_pass++;
    n_checks++;
    if (result_id !== 2'd0) $display("FAIL reset_id: got %0d, required 0", result_id);
    else n_pass++;
    req = '0;
  endtask

  // All requesters held high straight out of reset: grants 0,1,2,3,0.
  task automatic test_back_to_back;
    for (int i = 0; i < NREQ; i++) set_ops(i, 2'(i), 8'(8'h11 * (i + 1)), 8'h0F);
    req = '1;
    for (int k = 0; k < 5; k++)
      push_exp(k % NREQ, lu_model(2'(k % NREQ), 8'(8'h11 * (k % NREQ + 1)), 8'h0F));
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (gnt !== 4'(1 << (k % NREQ)) || result_valid !== 1'b0)
        $display("FAIL b2b_grant%0d: gnt=%b valid=%b, required gnt=%b valid=0",
                 k, gnt, result_valid, 4'(1 << (k % NREQ)));
      else n_pass++;
      if (k == 4) req = '0;
      @(negedge clk);
      n_checks++;
      if (gnt !== 4'b0000 || result_valid !== 1'b1)
        $display("FAIL b2b_valid%0d: gnt=%b valid=%b, required gnt=0000 valid=1",
                 k, gnt, result_valid);
      else n_pass++;
    end
  endtask

  task automatic test_single;
    set_ops(0, 2'b00, 8'hA0, 8'h05);
    req = 4'b0001;
    push_exp(0, 8'hA5);
    @(negedge clk);
    n_checks++;
    if (gnt !== 4'b0001) $display("FAIL single_gnt: got %b, required 0001", gnt);
    else n_pass++;
    req = '0;
    @(negedge clk);
    n_checks++;
    if (result_valid !== 1'b1 || gnt !== 4'b0000)
      $display("FAIL single_valid: valid=%b gnt=%b, required valid=1 gnt=0000",
               result_valid, gnt);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (result_valid !== 1'b0 || result !== 8'hA5 || result_id !== 2'd0 || gnt !== 4'b0000)
      $display("FAIL single_hold: valid=%b result=%h id=%0d gnt=%b, required 0 A5 0 0000",
               result_valid, result, result_id, gnt);
    else n_pass++;
  endtask

  task automatic test_opcode_sweep;
    logic [7:0] tbl [4];
    tbl[0] = 8'hFC;
    tbl[1] = 8'h30;
    tbl[2] = 8'hCC;
    tbl[3] = 8'h03;
    for (int o = 0; o < 4; o++) begin
      set_ops(2, 2'(o), 8'hF0, 8'h3C);
      req = 4'b0100;
      push_exp(2, tbl[o]);
      @(negedge clk);
      n_checks++;
      if (gnt !== 4'b0100) $display("FAIL sweep_gnt%0d: got %b, required 0100", o, gnt);
      else n_pass++;
      req = '0;
      @(negedge clk);
      n_checks++;
      if (result_valid !== 1'b1)
        $display("FAIL sweep_valid%0d: got %b, required 1", o, result_valid);
      else n_pass++;
    end
  endtask

  // Pointer sits at 3 here: req=1001 grants 3, then wraps to 0, then 3 again.
  task automatic test_wrap;
    int order [3];
    order[0] = 3;
    order[1] = 0;
    order[2] = 3;
    set_ops(3, 2'b10, 8'h55, 8'h0F);
    set_ops(0, 2'b01, 8'hF3, 8'h3F);
    req = 4'b1001;
    push_exp(3, 8'h5A);
    push_exp(0, 8'h33);
    push_exp(3, 8'h5A);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (gnt !== 4'(1 << order[k]))
        $display("FAIL wrap_gnt%0d: got %b, required %b", k, gnt, 4'(1 << order[k]));
      else n_pass++;
      if (k == 2) req = '0;
      @(negedge clk);
      n_checks++;
      if (result_valid !== 1'b1)
        $display("FAIL wrap_valid%0d: got %b, required 1", k, result_valid);
      else n_pass++;
    end
  endtask

  task automatic test_operand_change;
    set_ops(1, 2'b00, 8'h01, 8'h02);
    req = 4'b0010;
    push_exp(1, 8'h03);
    @(negedge clk);
    n_checks++;
    if (gnt !== 4'b0010) $display("FAIL opchg_gnt: got %b, required 0010", gnt);
    else n_pass++;
    req  = '0;
    a_in = '1;
    b_in = '1;
    op   = '1;
    @(negedge clk);
    n_checks++;
    if (result_valid !== 1'b1) $display("FAIL opchg_valid: got %b, required 1", result_valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid_exec;
    set_ops(2, 2'b01, 8'hFF, 8'hFF);
    req = 4'b0100;
    @(negedge clk);
    n_checks++;
    if (gnt !== 4'b0100) $display("FAIL rstx_gnt: got %b, required 0100", gnt);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (gnt !== 4'b0000 || result !== 8'h00 || result_valid !== 1'b0 || result_id !== 2'd0)
      $display("FAIL rstx_outputs: gnt=%b result=%h valid=%b id=%0d, required all 0",
               gnt, result, result_valid, result_id);
    else n_pass++;
    set_ops(0, 2'b11, 8'h0F, 8'h30);
    set_ops(3, 2'b00, 8'h01, 8'h01);
    req = 4'b1001;
    @(negedge clk);
    rst_n = 1'b1;
    push_exp(0, 8'hC0);
    @(negedge clk);
    n_checks++;
    if (gnt !== 4'b0001 || result_valid !== 1'b0)
      $display("FAIL rstx_regrant: gnt=%b valid=%b, required gnt=0001 valid=0",
               gnt, result_valid);
    else n_pass++;
    req = '0;
    @(negedge clk);
    n_checks++;
    if (result_valid !== 1'b1) $display("FAIL rstx_valid: got %b, required 1", result_valid);
    else n_pass++;
  endtask

  task automatic drain;
    int budget;
    budget = 8;
    while (sb.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) $display("FAIL drain: %0d results outstanding, required 0", sb.size());
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_single;
    test_opcode_sweep;
    test_wrap;
    test_operand_change;
    test_reset_mid_exec;
    drain;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
